if_id_stage: RTL and testbench
==============================

# if_id_stage

Fetch-to-decode pipeline stage of the 16-bit 5-stage CPU. It registers the fetched instruction and PC and decodes the opcode into register fields and the 2-bit immediate-format select consumed by the sign extender. It also detects load-use hazards and inserts a one-cycle bubble, applies branch flushes and implements HALT. `id_instr` and `id_ext_sel` drive the sign extender's `in` and `select` inputs directly.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `fetch_valid` in 1: fetch offers an instruction.
- `fetch_instr` in 16: instruction word.
- `fetch_pc` in 16: PC of `fetch_instr`.
- `fetch_ready` out 1: stage accepts this cycle.
- `flush` in 1: taken branch in EX; discard the held instruction.
- `ex_ready` in 1: EX can take an instruction this cycle.
- `id_valid` out 1: `id_*` carry a real instruction.
- `id_instr` out 16: held instruction; sign extender `in`.
- `id_pc` out 16: held PC.
- `id_ext_sel` out 2: sign extender `select`.
- `id_rd`, `id_rs`, `id_rt` out 4 each: fields [11:8], [7:4], [3:0].
- `id_is_load` out 1: held instruction is LW.
- `halted` out 1: HALT has issued.
- `bubble_count` out 16: present only with `IF_ID_PERF_EN`.

## Operation
Decode from opcode [15:12]. Columns are ext_sel; source regs; flags.
- 0x0–0x7 ALU: ext_sel 01; sources rs, rt.
- 0x8 ADDI: ext_sel 01; source rs.
- 0x9 LW: ext_sel 01; source rs; load.
- 0xA SW: ext_sel 01; sources rs, rd.
- 0xB LI: ext_sel 10; no sources.
- 0xC BEQ: ext_sel 00; sources rd, rt.
- 0xD JMP: ext_sel 11; no sources.
- 0xE NOP: ext_sel 01; no sources.
- 0xF HALT: ext_sel 01; no sources; halt.

Internal state:
- `full` bit, instruction register, PC register.
- Load tracker `{ld_pending, ld_rd}`.
- FSM with states RUN and HALTED.

Combinational terms:
- `hazard` = `ld_pending` & `full` & (a decoded source register equals `ld_rd`).
- `id_valid` = `full` & !`hazard` & !`flush` & RUN.
- `issue` = `id_valid` & `ex_ready`.
- `fetch_ready` = RUN & !`flush` & (!`full` | `issue`).
- `accept` = `fetch_valid` & `fetch_ready`.

Register updates:
- `full`: cleared on `flush`; else set on `accept`; else cleared on `issue`.
- Instruction and PC registers load only on `accept`.
- Tracker: cleared on `flush`. Otherwise, when `ex_ready` is 1, load `ld_pending` ← `issue` & `id_is_load` and `ld_rd` ← `id_rd`. Hold when `ex_ready` is 0.
- FSM: RUN→HALTED on `issue` of HALT. HALTED is left only by reset.

Rules and boundary conditions:
- A bubble is a cycle with `full` & `hazard` & `ex_ready` & RUN. It clears `ld_pending`, so the next cycle issues.
- `flush` overrides accept and issue in the same cycle.
- In HALTED: `halted`=1, `id_valid`=0, `fetch_ready`=0. Registers hold, apart from `flush` effects.
- Reset asserted mid-operation discards the held instruction with no issue.

## Timing
- Reset values:
  - `full`=0, instruction register=0x0000, PC register=0x0000.
  - `ld_pending`=0, `ld_rd`=0, FSM=RUN.
  - Outputs: `fetch_ready`=1 (when `flush`=0), `id_valid`=0, `halted`=0, `bubble_count`=0.
  - `id_*` show the decode of 0x0000: ext_sel 01, all fields 0.
- Latency: accepted at edge N, visible on `id_*` after edge N (cycle N+1). Throughput is 1 per cycle with `ex_ready`=1 and no hazard.
- A load followed immediately by a dependent instruction costs exactly one bubble cycle.
- All `id_*` outputs are registered or decoded from registers only. No path from `fetch_*` to `id_*`.

## Configuration
- `IF_ID_PERF_EN` defined: adds `bubble_count`.
  - Resets to 0 and increments on each bubble cycle.
  - Saturates at 0xFFFF.
  - Unaffected by `flush`.
- Not defined: no counter and no `bubble_count` port. All other behaviour is identical.

## Test plan
- Streaming: feed 0x8123 then 0xB2FF with `ex_ready`=1 → issue on consecutive cycles. `id_ext_sel` is 01 then 10; `id_rd` is 1 then 2.
- Load-use: issue LW 0x9310 (rd=3), then ALU 0x0435 (rt=5, then rs=3 in 0x0435's [7:4]) → exactly one cycle with `id_valid`=0 and `fetch_ready`=0. The ALU issues the following cycle; `bubble_count` = 1.
- No false hazard: LW rd=3 followed by LI 0xB3AA → no bubble.
- Flush: `full`=1 holding 0xC120, `flush`=1 with `fetch_valid`=1 → nothing issued and nothing accepted. Next cycle `id_valid`=0 and `ld_pending`=0.
- Backpressure: hold `ex_ready`=0 for 3 cycles with a held JMP 0xD7FF → `id_instr` stable, `id_ext_sel`=11, `fetch_ready`=0. The JMP issues on the first cycle `ex_ready`=1.
- Halt and reset: HALT 0xF000 issues → `halted`=1 and `fetch_ready`=0 forever. `rst_n`=0 for one edge → all reset values restored and `fetch_ready`=1.

Source files
------------

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Fetch-to-decode pipeline register of the 16-bit 5-stage CPU.
// It holds one fetched instruction and its PC, and decodes the held opcode
// into register fields and the sign-extender format select. It also:
//   - detects load-use hazards and inserts a single bubble,
//   - discards the held instruction on a branch flush,
//   - stops the front end permanently once HALT issues (until reset).
//
// Optional feature macro: IF_ID_PERF_EN
//   When defined, adds the bubble_count output, a saturating 16-bit count of
//   bubble cycles. When undefined, the port and counter do not exist.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst_n         in   1   synchronous reset, active low
//   fetch_valid   in   1   fetch offers an instruction
//   fetch_instr   in  16   offered instruction word
//   fetch_pc      in  16   PC of fetch_instr
//   fetch_ready   out  1   stage accepts the offered instruction this cycle
//   flush         in   1   taken branch in EX, drop the held instruction
//   ex_ready      in   1   EX can take an instruction this cycle
//   id_valid      out  1   id_* carry a real instruction
//   id_instr      out 16   held instruction (sign extender input)
//   id_pc         out 16   held PC
//   id_ext_sel    out  2   sign extender format select
//   id_rd         out  4   instruction field [11:8]
//   id_rs         out  4   instruction field [7:4]
//   id_rt         out  4   instruction field [3:0]
//   id_is_load    out  1   held instruction is LW
//   halted        out  1   HALT has issued
//   bubble_count  out 16   bubble cycles (IF_ID_PERF_EN only)
// ---------------------------------------------------------------------------
module if_id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_instr,
  input  logic [15:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [1:0]  id_ext_sel,
  output logic [3:0]  id_rd,
  output logic [3:0]  id_rs,
  output logic [3:0]  id_rt,
  output logic        id_is_load,
  output logic        halted
`ifdef IF_ID_PERF_EN
  ,
  output logic [15:0] bubble_count
`endif
);

  // Opcode values that need special handling in decode.
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_LI   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Sign extender format selects.
  localparam logic [1:0] EXT_BRANCH = 2'b00;
  localparam logic [1:0] EXT_STD    = 2'b01;
  localparam logic [1:0] EXT_LI     = 2'b10;
  localparam logic [1:0] EXT_JMP    = 2'b11;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic        full_reg;
  logic [15:0] instr_reg;
  logic [15:0] pc_reg;
  logic        ld_pending_reg;
  logic [3:0]  ld_rd_reg;
  state_t      state_reg;
  logic        halted_reg;

  // -------------------------------------------------------------------------
  // Decode of the held instruction (registers only, no fetch_* paths)
  // -------------------------------------------------------------------------
  logic [3:0] opcode;
  logic [1:0] ext_sel;
  logic       use_rs;
  logic       use_rt;
  logic       use_rd;
  logic       is_load;
  logic       is_halt;

  assign opcode = instr_reg[15:12];

  always_comb begin
    ext_sel = EXT_STD;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    use_rd  = 1'b0;
    is_load = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_ADDI: begin
        use_rs = 1'b1;
      end
      OP_LW: begin
        use_rs  = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        // Store data comes from the rd field.
        use_rs = 1'b1;
        use_rd = 1'b1;
      end
      OP_LI: begin
        ext_sel = EXT_LI;
      end
      OP_BEQ: begin
        // Branch compares rd with rt.
        ext_sel = EXT_BRANCH;
        use_rd  = 1'b1;
        use_rt  = 1'b1;
      end
      OP_JMP: begin
        ext_sel = EXT_JMP;
      end
      OP_NOP: begin
        ext_sel = EXT_STD;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        ext_sel = EXT_STD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Load-use hazard: any source actually read by the held instruction that
  // matches the destination of the load currently in EX.
  // -------------------------------------------------------------------------
  logic [2:0] src_used;
  logic [3:0] src_addr [3];
  logic [2:0] src_match;

  assign src_used    = {use_rd, use_rt, use_rs};
  assign src_addr[0] = instr_reg[7:4];
  assign src_addr[1] = instr_reg[3:0];
  assign src_addr[2] = instr_reg[11:8];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src_match
      assign src_match[gi] = src_used[gi] && (src_addr[gi] == ld_rd_reg);
    end
  endgenerate

  logic run;
  logic hazard;
  logic issue;
  logic accept;
  logic bubble;

  assign run    = (state_reg == ST_RUN);
  assign hazard = ld_pending_reg && full_reg && (|src_match);
  assign issue  = id_valid && ex_ready;
  assign accept = fetch_valid && fetch_ready;
  // A bubble stalls the held instruction for one cycle while EX is free;
  // clearing ld_pending below guarantees it issues on the next cycle.
  assign bubble = full_reg && hazard && ex_ready && run;

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign id_valid    = full_reg && !hazard && !flush && run;
  assign fetch_ready = run && !flush && (!full_reg || issue);

  assign id_instr   = instr_reg;
  assign id_pc      = pc_reg;
  assign id_ext_sel = ext_sel;
  assign id_rd      = instr_reg[11:8];
  assign id_rs      = instr_reg[7:4];
  assign id_rt      = instr_reg[3:0];
  assign id_is_load = is_load;
  assign halted     = halted_reg;

  // -------------------------------------------------------------------------
  // Pipeline register. flush has priority over accept and issue.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_reg  <= 1'b0;
      instr_reg <= 16'h0000;
      pc_reg    <= 16'h0000;
    end else begin
      if (flush) begin
        full_reg <= 1'b0;
      end else if (accept) begin
        full_reg <= 1'b1;
      end else if (issue) begin
        full_reg <= 1'b0;
      end
      if (accept) begin
        instr_reg <= fetch_instr;
        pc_reg    <= fetch_pc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Load tracker: mirrors whether the instruction now entering EX is a load
  // and which register it writes. It only advances when EX advances.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_pending_reg <= 1'b0;
      ld_rd_reg      <= 4'h0;
    end else if (flush) begin
      ld_pending_reg <= 1'b0;
      ld_rd_reg      <= 4'h0;
    end else if (ex_ready && run) begin
      ld_pending_reg <= issue && is_load;
      ld_rd_reg      <= instr_reg[11:8];
    end
  end

  // -------------------------------------------------------------------------
  // Run/halt FSM. HALTED is sticky until reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (issue && is_halt) begin
            state_reg  <= ST_HALTED;
            halted_reg <= 1'b1;
          end
        end
        ST_HALTED: begin
          state_reg  <= ST_HALTED;
          halted_reg <= 1'b1;
        end
        default: begin
          state_reg  <= ST_RUN;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_EN
  // -------------------------------------------------------------------------
  // Saturating bubble counter, unaffected by flush.
  // -------------------------------------------------------------------------
  logic [15:0] bubble_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_count_reg <= 16'h0000;
    end else if (bubble && (bubble_count_reg != 16'hFFFF)) begin
      bubble_count_reg <= bubble_count_reg + 16'h0001;
    end
  end

  assign bubble_count = bubble_count_reg;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed, self-checking bench for if_id_stage. Inputs change 1 ns after
// each rising edge; outputs are checked 2 ns after the edge, well clear of
// the next rising edge. One line is printed for every issued instruction.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic [15:0] fetch_pc;
  logic        fetch_ready;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [1:0]  id_ext_sel;
  logic [3:0]  id_rd;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_is_load;
  logic        halted;
`ifdef IF_ID_PERF_EN
  logic [15:0] bubble_count;
`endif

  int vectors;
  int miscompares;

  if_id_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ext_sel  (id_ext_sel),
    .id_rd       (id_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_is_load  (id_is_load),
    .halted      (halted)
`ifdef IF_ID_PERF_EN
    ,
    .bubble_count(bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per issued instruction.
  always @(posedge clk) begin
    if (rst_n && id_valid && ex_ready)
      $display("issue pc=%h instr=%h", id_pc, id_instr);
  end

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [15:0] instr, input logic [15:0] pc);
    fetch_valid = 1'b1;
    fetch_instr = instr;
    fetch_pc    = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    vectors++;
    if (fetch_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready);
    end
    vectors++;
    if (id_valid !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_halted: got %b/%b want 0/0", id_valid, halted);
    end
    vectors++;
    if (id_instr !== 16'h0000 || id_pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_regs: got instr=%h pc=%h want 0000/0000", id_instr, id_pc);
    end
    vectors++;
    if (id_ext_sel !== 2'b01 || id_rd !== 4'h0 || id_rs !== 4'h0 || id_rt !== 4'h0 || id_is_load !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_decode: got sel=%b rd=%h rs=%h rt=%h ld=%b want 01/0/0/0/0",
               id_ext_sel, id_rd, id_rs, id_rt, id_is_load);
    end
`ifdef IF_ID_PERF_EN
    vectors++;
    if (bubble_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_bubble_count: got %h want 0000", bubble_count);
    end
`endif
  endtask

  task automatic test_streaming();
    ex_ready = 1'b1;
    offer(16'h8123, 16'h0010);
    tick();
    offer(16'hB2FF, 16'h0012);
    settle();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 16'h8123 || id_ext_sel !== 2'b01 || id_rd !== 4'h1) begin
      miscompares++;
      $display("FAIL stream_addi: got v=%b instr=%h sel=%b rd=%h want 1/8123/01/1",
               id_valid, id_instr, id_ext_sel, id_rd);
    end
    vectors++;
    if (fetch_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stream_ready: got %b want 1", fetch_ready);
    end
    tick();
    fetch_valid = 1'b0;
    settle();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 16'hB2FF || id_ext_sel !== 2'b10 || id_rd !== 4'h2 || id_pc !== 16'h0012) begin
      miscompares++;
      $display("FAIL stream_li: got v=%b instr=%h sel=%b rd=%h pc=%h want 1/b2ff/10/2/0012",
               id_valid, id_instr, id_ext_sel, id_rd, id_pc);
    end
    tick();
    settle();
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_drain: got id_valid=%b want 0", id_valid);
    end
  endtask

  task automatic test_load_use();
    offer(16'h9310, 16'h0020);
    tick();
    offer(16'h0435, 16'h0022);
    settle();
    vectors++;
    if (id_valid !== 1'b1 || id_is_load !== 1'b1 || id_rd !== 4'h3) begin
      miscompares++;
      $display("FAIL lu_load: got v=%b ld=%b rd=%h want 1/1/3", id_valid, id_is_load, id_rd);
    end
    tick();
    fetch_valid = 1'b0;
    settle();
    vectors++;
    if (id_valid !== 1'b0 || fetch_ready !== 1'b0 || id_instr !== 16'h0435 || id_rs !== 4'h3) begin
      miscompares++;
      $display("FAIL lu_bubble: got v=%b rdy=%b instr=%h rs=%h want 0/0/0435/3",
               id_valid, fetch_ready, id_instr, id_rs);
    end
    tick();
    settle();
    vectors++;
    if (id_valid !== 1'b1 || fetch_ready !== 1'b1 || id_instr !== 16'h0435) begin
      miscompares++;
      $display("FAIL lu_issue: got v=%b rdy=%b instr=%h want 1/1/0435", id_valid, fetch_ready, id_instr);
    end
`ifdef IF_ID_PERF_EN
    vectors++;
    if (bubble_count !== 16'h0001) begin
      miscompares++;
      $display("FAIL lu_bubble_count: got %h want 0001", bubble_count);
    end
`endif
    tick();
  endtask

  task automatic test_no_false_hazard();
    offer(16'h9310, 16'h0030);
    tick();
    offer(16'hB3AA, 16'h0032);
    settle();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 16'h9310) begin
      miscompares++;
      $display("FAIL nfh_load: got v=%b instr=%h want 1/9310", id_valid, id_instr);
    end
    tick();
    fetch_valid = 1'b0;
    settle();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 16'hB3AA || id_ext_sel !== 2'b10) begin
      miscompares++;
      $display("FAIL nfh_li: got v=%b instr=%h sel=%b want 1/b3aa/10", id_valid, id_instr, id_ext_sel);
    end
`ifdef IF_ID_PERF_EN
    vectors++;
    if (bubble_count !== 16'h0001) begin
      miscompares++;
      $display("FAIL nfh_bubble_count: got %h want 0001", bubble_count);
    end
`endif
    tick();
  endtask

  task automatic test_flush();
    // LW r1 then BEQ reading r1: the BEQ is held behind a hazard.
    offer(16'h9100, 16'h0040);
    tick();
    offer(16'hC120, 16'h0042);
    tick();
    ex_ready = 1'b0;
    flush    = 1'b1;
    offer(16'hE000, 16'h0044);
    settle();
    vectors++;
    if (id_valid !== 1'b0 || fetch_ready !== 1'b0 || id_instr !== 16'hC120 || id_ext_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_cycle: got v=%b rdy=%b instr=%h sel=%b want 0/0/c120/00",
               id_valid, fetch_ready, id_instr, id_ext_sel);
    end
    tick();
    flush       = 1'b0;
    ex_ready    = 1'b1;
    fetch_valid = 1'b0;
    settle();
    vectors++;
    if (id_valid !== 1'b0 || fetch_ready !== 1'b1 || id_instr !== 16'hC120) begin
      miscompares++;
      $display("FAIL flush_after: got v=%b rdy=%b instr=%h want 0/1/c120", id_valid, fetch_ready, id_instr);
    end
    // Same BEQ again: with the tracker cleared it must issue without a bubble.
    offer(16'hC120, 16'h0046);
    tick();
    fetch_valid = 1'b0;
    settle();
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 16'h0046) begin
      miscompares++;
      $display("FAIL flush_tracker_clear: got v=%b pc=%h want 1/0046", id_valid, id_pc);
    end
    tick();
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    offer(16'hD7FF, 16'h0050);
    tick();
    offer(16'hE000, 16'h0052);
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++;
      if (id_valid !== 1'b1 || id_instr !== 16'hD7FF || id_ext_sel !== 2'b11 || fetch_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got v=%b instr=%h sel=%b rdy=%b want 1/d7ff/11/0",
                 i, id_valid, id_instr, id_ext_sel, fetch_ready);
      end
      tick();
    end
    ex_ready = 1'b1;
    settle();
    vectors++;
    if (id_valid !== 1'b1 || fetch_ready !== 1'b1 || id_instr !== 16'hD7FF) begin
      miscompares++;
      $display("FAIL bp_release: got v=%b rdy=%b instr=%h want 1/1/d7ff", id_valid, fetch_ready, id_instr);
    end
    tick();
    fetch_valid = 1'b0;
    settle();
    vectors++;
    if (id_valid !== 1'b1 || id_instr !== 16'hE000 || id_pc !== 16'h0052) begin
      miscompares++;
      $display("FAIL bp_next: got v=%b instr=%h pc=%h want 1/e000/0052", id_valid, id_instr, id_pc);
    end
    tick();
  endtask

  task automatic test_halt_reset();
    offer(16'hF000, 16'h0060);
    tick();
    offer(16'h8123, 16'h0062);
    settle();
    vectors++;
    if (id_valid !== 1'b1 || fetch_ready !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_issue: got v=%b rdy=%b halted=%b want 1/1/0", id_valid, fetch_ready, halted);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++;
      if (halted !== 1'b1 || fetch_ready !== 1'b0 || id_valid !== 1'b0 || id_instr !== 16'h8123) begin
        miscompares++;
        $display("FAIL halt_hold%0d: got halted=%b rdy=%b v=%b instr=%h want 1/0/0/8123",
                 i, halted, fetch_ready, id_valid, id_instr);
      end
      tick();
    end
    fetch_valid = 1'b0;
    rst_n       = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    vectors++;
    if (halted !== 1'b0 || fetch_ready !== 1'b1 || id_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_reset_ctrl: got halted=%b rdy=%b v=%b want 0/1/0", halted, fetch_ready, id_valid);
    end
    vectors++;
    if (id_instr !== 16'h0000 || id_pc !== 16'h0000 || id_ext_sel !== 2'b01) begin
      miscompares++;
      $display("FAIL halt_reset_regs: got instr=%h pc=%h sel=%b want 0000/0000/01", id_instr, id_pc, id_ext_sel);
    end
`ifdef IF_ID_PERF_EN
    vectors++;
    if (bubble_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL halt_reset_bubble_count: got %h want 0000", bubble_count);
    end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = 16'h0000;
    fetch_pc    = 16'h0000;
    flush       = 1'b0;
    ex_ready    = 1'b1;

    test_reset();
    test_streaming();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_backpressure();
    test_halt_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
